spi_cmd_framer: RTL and testbench

Upstream command stage for the SD-card SPI core. It accepts a command index and 32-bit argument and builds the 48-bit SD command frame, with a serially computed CRC7. It hands the frame to the core over a valid/ready handshake. It then watches returned response bytes for the R1 token and reports either R1 or a timeout.

---
 rtl/spi_cmd_framer_if.sv | 30 +++
 rtl/spi_cmd_framer.sv | 161 ++++++++++++++++
 tb/tb_spi_cmd_framer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_framer_if.sv
// Handshake bundle between a command source, the frame builder and the SPI core.
// slave: the framer's view. master: the view of whatever drives it (source/core/bench).
interface spi_cmd_framer_if #(
    parameter int COMMAND_WIDTH      = 48,
    parameter int INTERNAL_DAT_WIDTH = 8
);
    logic [5:0]                    cmd_idx_i;
    logic [31:0]                   cmd_arg_i;
    logic                          cmd_valid_i;
    logic                          cmd_ready_o;
    logic [COMMAND_WIDTH-1:0]      frame_o;
    logic                          frame_valid_o;
    logic                          frame_ready_i;
    logic [INTERNAL_DAT_WIDTH-1:0] rsp_byte_i;
    logic                          rsp_valid_i;
    logic [INTERNAL_DAT_WIDTH-1:0] resp_o;
    logic                          resp_valid_o;
    logic                          timeout_o;
    logic                          busy_o;

    modport slave (
        input  cmd_idx_i, cmd_arg_i, cmd_valid_i, frame_ready_i, rsp_byte_i, rsp_valid_i,
        output cmd_ready_o, frame_o, frame_valid_o, resp_o, resp_valid_o, timeout_o, busy_o
    );

    modport master (
        output cmd_idx_i, cmd_arg_i, cmd_valid_i, frame_ready_i, rsp_byte_i, rsp_valid_i,
        input  cmd_ready_o, frame_o, frame_valid_o, resp_o, resp_valid_o, timeout_o, busy_o
    );
endinterface

// File: rtl/spi_cmd_framer.sv
// SD-card SPI command framer: builds the 48-bit command frame, hands it to the
// core over valid/ready, then polls response bytes for the R1 token or a timeout.
// Build option SPI_CMD_CRC_EN: when defined, CRC7 is computed serially (one bit
// per cycle over 40 bits); when undefined the CRC field is fixed at 7'h7F and the
// frame is presented on the cycle right after the command is accepted.
module spi_cmd_framer #(
    parameter int COMMAND_WIDTH      = 48,
    parameter int INTERNAL_DAT_WIDTH = 8,
    parameter int NCR_MAX            = 8
) (
    input  logic            clk,
    input  logic            rst,
    spi_cmd_framer_if.slave bus
);

`ifdef SPI_CMD_CRC_EN
    typedef enum logic [2:0] {IDLE, CRC, SEND, WAIT_R1, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT_R1, DONE} state_t;
`endif

    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

    state_t                        state_q, state_d;
    logic [COMMAND_WIDTH-1:0]      frame_q, frame_d;
    logic [INTERNAL_DAT_WIDTH-1:0] resp_q, resp_d;
    logic [7:0]                    byte_cnt_q, byte_cnt_d;
    logic                          got_r1_q, got_r1_d;

`ifdef SPI_CMD_CRC_EN
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] msg;
    logic        crc_fb;
`endif

    logic cmd_fire, frame_fire, rsp_fire, rsp_msb, is_r1, ncr_hit;

    // Handshake qualifiers shared by the next-state and datapath logic.
    always_comb begin
        cmd_fire   = bus.cmd_valid_i && (state_q == IDLE);
        frame_fire = (state_q == SEND) && bus.frame_ready_i;
        rsp_fire   = (state_q == WAIT_R1) && bus.rsp_valid_i;
        rsp_msb    = bus.rsp_byte_i[INTERNAL_DAT_WIDTH-1];
        is_r1      = rsp_fire && !rsp_msb;
        ncr_hit    = rsp_fire && rsp_msb && (byte_cnt_q == NCR_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef SPI_CMD_CRC_EN
                if (cmd_fire) state_d = CRC;
`else
                if (cmd_fire) state_d = SEND;
`endif
            end
`ifdef SPI_CMD_CRC_EN
            CRC:     if (bit_cnt_q == 6'd40) state_d = SEND;
`endif
            SEND:    if (frame_fire) state_d = WAIT_R1;
            WAIT_R1: if (is_r1 || ncr_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_CMD_CRC_EN
    // Serial CRC7 feedback: message bit selected MSB-first by the bit counter.
    always_comb begin
        msg    = {2'b01, idx_q, arg_q};
        crc_fb = msg[6'd39 - bit_cnt_q] ^ crc_q[6];
    end
`endif

    // Datapath next values: command latch, CRC shift, frame load, response capture.
    always_comb begin
        frame_d    = frame_q;
        resp_d     = resp_q;
        byte_cnt_d = byte_cnt_q;
        got_r1_d   = got_r1_q;
`ifdef SPI_CMD_CRC_EN
        idx_d      = idx_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        if (cmd_fire) begin
            idx_d     = bus.cmd_idx_i;
            arg_d     = bus.cmd_arg_i;
            crc_d     = 7'd0;
            bit_cnt_d = 6'd0;
        end
        if (state_q == CRC) begin
            if (bit_cnt_q == 6'd40) begin
                frame_d = {2'b01, idx_q, arg_q, crc_q, 1'b1};
            end else begin
                crc_d     = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end
`else
        if (cmd_fire) frame_d = {2'b01, bus.cmd_idx_i, bus.cmd_arg_i, 7'h7F, 1'b1};
`endif
        if (frame_fire) byte_cnt_d = 8'd0;
        if (rsp_fire && rsp_msb) byte_cnt_d = byte_cnt_q + 8'd1;
        if (is_r1) begin
            resp_d   = bus.rsp_byte_i;
            got_r1_d = 1'b1;
        end
        if (ncr_hit) got_r1_d = 1'b0;
    end

    // Datapath registers; everything clears on reset so an aborted command leaves no trace.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q    <= '0;
            resp_q     <= '0;
            byte_cnt_q <= '0;
            got_r1_q   <= 1'b0;
`ifdef SPI_CMD_CRC_EN
            idx_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            bit_cnt_q  <= '0;
`endif
        end else begin
            frame_q    <= frame_d;
            resp_q     <= resp_d;
            byte_cnt_q <= byte_cnt_d;
            got_r1_q   <= got_r1_d;
`ifdef SPI_CMD_CRC_EN
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
`endif
        end
    end

    // Outputs decoded from the registered state; DONE lasts one cycle so pulses do too.
    always_comb begin
        bus.cmd_ready_o   = (state_q == IDLE);
        bus.busy_o        = (state_q != IDLE);
        bus.frame_valid_o = (state_q == SEND);
        bus.frame_o       = frame_q;
        bus.resp_o        = resp_q;
        bus.resp_valid_o  = (state_q == DONE) && got_r1_q;
        bus.timeout_o     = (state_q == DONE) && !got_r1_q;
    end

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Scoreboard bench for spi_cmd_framer: stimulus pushes expected frames and
// response outcomes; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_spi_cmd_framer;
    localparam int NCR_MAX = 8;
`ifdef SPI_CMD_CRC_EN
    localparam bit CRC_ON = 1'b1;
    localparam int LAT    = 41;
`else
    localparam bit CRC_ON = 1'b0;
    localparam int LAT    = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cmd_framer_if u_if ();

    spi_cmd_framer #(
        .COMMAND_WIDTH(48),
        .INTERNAL_DAT_WIDTH(8),
        .NCR_MAX(NCR_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    typedef struct packed {
        logic       is_to;
        logic [7:0] resp;
    } outcome_t;

    int          checks = 0;
    int          errors = 0;
    int          outcomes_seen = 0;
    bit          mon_en = 1'b0;
    logic [47:0] exp_frames[$];
    outcome_t    exp_out[$];
    logic [7:0]  model_resp = 8'h00;
    logic [47:0] mon_frame;
    outcome_t    mon_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, (CRC_ON ? crc7_ref(m) : 7'h7F), 1'b1};
    endfunction

    // Monitor: compare frames on handshake and outcomes on pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (u_if.frame_valid_o && u_if.frame_ready_i) begin
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame actual=%0h required=none", u_if.frame_o);
                end else begin
                    mon_frame = exp_frames.pop_front();
                    check("frame_o", 64'(u_if.frame_o), 64'(mon_frame));
                end
            end
            if (u_if.resp_valid_o || u_if.timeout_o) begin
                check("pulse_exclusive", 64'(u_if.resp_valid_o & u_if.timeout_o), 64'(0));
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual=rv%0d/to%0d required=none",
                             u_if.resp_valid_o, u_if.timeout_o);
                end else begin
                    mon_out = exp_out.pop_front();
                    check("timeout_o", 64'(u_if.timeout_o), 64'(mon_out.is_to));
                    check("resp_valid_o", 64'(u_if.resp_valid_o), 64'(!mon_out.is_to));
                    check("resp_o", 64'(u_if.resp_o), 64'(mon_out.resp));
                end
                outcomes_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] exp_frame, input int n_ff,
                           input logic [7:0] r1, input bit fixed_ff, input bit junk);
        int lat;
        int d;
        int base;
        int n_feed;
        bit is_to;
        outcome_t o;
        exp_frames.push_back(exp_frame);
        u_if.cmd_idx_i   = idx;
        u_if.cmd_arg_i   = arg;
        u_if.cmd_valid_i = 1'b1;
        check("ready_before_accept", 64'(u_if.cmd_ready_o), 64'(1));
        step();
        u_if.cmd_valid_i = 1'b0;
        check("busy_after_accept", 64'(u_if.busy_o), 64'(1));
        lat = 0;
        while (!u_if.frame_valid_o && lat < 100) begin
            if (junk) begin
                u_if.cmd_valid_i = 1'b1;
                u_if.cmd_idx_i   = ~idx;
                u_if.cmd_arg_i   = ~arg;
            end
            step();
            lat++;
        end
        check("frame_latency", 64'(lat), 64'(LAT));
        d = $urandom_range(0, 3);
        repeat (d) begin
            u_if.cmd_valid_i = junk;
            u_if.rsp_byte_i  = 8'h00;
            u_if.rsp_valid_i = junk;
            step();
            u_if.rsp_valid_i = 1'b0;
            check("frame_valid_hold", 64'(u_if.frame_valid_o), 64'(1));
        end
        u_if.cmd_valid_i   = 1'b0;
        u_if.frame_ready_i = 1'b1;
        step();
        u_if.frame_ready_i = 1'b0;
        check("frame_valid_drop", 64'(u_if.frame_valid_o), 64'(0));

        is_to  = (n_ff >= NCR_MAX);
        n_feed = is_to ? NCR_MAX : n_ff + 1;
        if (!is_to) model_resp = r1;
        o.is_to = is_to;
        o.resp  = model_resp;
        exp_out.push_back(o);
        base = outcomes_seen;
        for (int i = 0; i < n_feed; i++) begin
            repeat ($urandom_range(0, 2)) step();
            u_if.rsp_byte_i  = (i < n_ff) ? (fixed_ff ? 8'hFF : (8'h80 | 8'($urandom))) : r1;
            u_if.rsp_valid_i = 1'b1;
            step();
            u_if.rsp_valid_i = 1'b0;
        end
        for (int w = 0; w < 10 && outcomes_seen == base; w++) step();
        check("outcome_seen", 64'(outcomes_seen), 64'(base + 1));
        step();
        check("ready_after_done", 64'(u_if.cmd_ready_o), 64'(1));
        check("busy_after_done", 64'(u_if.busy_o), 64'(0));
        // A stray byte in IDLE must be ignored.
        u_if.rsp_byte_i  = 8'h00;
        u_if.rsp_valid_i = 1'b1;
        step();
        u_if.rsp_valid_i = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(u_if.cmd_ready_o), 64'(1));
        check({tag, "_busy"}, 64'(u_if.busy_o), 64'(0));
        check({tag, "_fvalid"}, 64'(u_if.frame_valid_o), 64'(0));
        check({tag, "_frame"}, 64'(u_if.frame_o), 64'(0));
        check({tag, "_resp"}, 64'(u_if.resp_o), 64'(0));
        check({tag, "_rvalid"}, 64'(u_if.resp_valid_o), 64'(0));
        check({tag, "_timeout"}, 64'(u_if.timeout_o), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  idx;
        logic [31:0] arg;
        rst                = 1'b0;
        u_if.cmd_idx_i     = '0;
        u_if.cmd_arg_i     = '0;
        u_if.cmd_valid_i   = 1'b0;
        u_if.frame_ready_i = 1'b0;
        u_if.rsp_byte_i    = '0;
        u_if.rsp_valid_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        step();
        mon_en = 1'b1;

        run_cmd(6'd0, 32'h0, CRC_ON ? 48'h400000000095 : 48'h4000000000FF, 2, 8'h01, 1'b1, 1'b1);
        run_cmd(6'd8, 32'h000001AA, CRC_ON ? 48'h48000001AA87 : 48'h48000001AAFF,
                NCR_MAX, 8'h00, 1'b1, 1'b0);
        run_cmd(6'd17, 32'h0, CRC_ON ? 48'h510000000055 : 48'h5100000000FF, 0, 8'h05, 1'b1, 1'b1);
        run_cmd(6'd55, 32'h0, frame_ref(6'd55, 32'h0), NCR_MAX - 1, 8'h7F, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            idx = 6'($urandom);
            arg = $urandom;
            run_cmd(idx, arg, frame_ref(idx, arg), $urandom_range(0, NCR_MAX + 2),
                    8'($urandom) & 8'h7F, 1'b0, 1'($urandom));
        end

        // Abort a command mid-flight; no frame, no pulse, everything cleared.
        u_if.cmd_idx_i   = 6'd9;
        u_if.cmd_arg_i   = 32'hDEADBEEF;
        u_if.cmd_valid_i = 1'b1;
        step();
        u_if.cmd_valid_i = 1'b0;
        repeat (5) step();
        check("busy_before_abort", 64'(u_if.busy_o), 64'(1));
        rst = 1'b0;
        #1;
        model_resp = 8'h00;
        check_reset_outputs("abort");
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("no_pulse_after_abort", 64'(u_if.resp_valid_o | u_if.timeout_o), 64'(0));

        idx = 6'($urandom);
        arg = $urandom;
        run_cmd(idx, arg, frame_ref(idx, arg), 1, 8'h00, 1'b0, 1'b0);

        repeat (3) step();
        check("frames_drained", 64'(exp_frames.size()), 64'(0));
        check("outcomes_drained", 64'(exp_out.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
